frag_streamer: RTL
==================

# frag_streamer

Downstream stage of the k-mer extender. It captures one batch of `INDICES_COUNT` extended fragments in a single handshake and streams them out one fragment per transfer on a valid/ready interface, tagged with the slot index. An optional filter discards fragments that contain too many 'N' bases before they reach the next consumer.

## Interface
- `FRAG_LEN`, default `proj_pkg::EXTENDER_FRAG_LEN`: bases per fragment.
- `BASE_LEN`, default `proj_pkg::BASE_LEN`: bits per base; 'N' is encoded as all zeros.
- `INDICES_COUNT`, default `proj_pkg::HASHER_EXTENDER_INDICES_COUNT`: fragments per batch.
- `MAX_N`, default 2: maximum number of 'N' bases a kept fragment may contain (used only with the filter).
- `IDX_W`, default `$clog2(INDICES_COUNT)` (minimum 1): slot tag width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  batch available.
- `in_ready`  out  1  block can accept a batch.
- `in_frags`  in  `[INDICES_COUNT][FRAG_LEN*BASE_LEN]`  batch, slot i holds fragment i.
- `out_valid`  out  1  `out_frag` valid.
- `out_ready`  in  1  consumer accepts.
- `out_frag`  out  `FRAG_LEN*BASE_LEN`  current fragment.
- `out_idx`  out  `IDX_W`  slot number of `out_frag`.
- `out_last`  out  1  current fragment is the last kept one of its batch.
- `drop_count`  out  16  saturating count of filtered fragments.

## Operation
- States:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - EMIT: `in_ready`=0.
- Capture (IDLE, `in_valid`&`in_ready`):
  - Register all slots into a buffer.
  - Register a keep mask (one bit per slot) computed from `in_frags` at capture.
  - If the mask is nonzero: go to EMIT with pointer = lowest set bit. Otherwise stay in IDLE.
- EMIT:
  - `out_frag` = buffer[pointer]; `out_idx` = pointer; `out_valid`=1.
  - `out_last`=1 when no set mask bit exists above the pointer.
  - On `out_valid`&`out_ready`: pointer jumps to the next set mask bit (priority encode, no idle cycles for skipped slots). If `out_last`=1, go to IDLE instead.
- `out_frag`, `out_idx` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` is ignored outside IDLE. `in_frags` is sampled only on the capture edge.
- N count: number of `BASE_LEN` fields equal to zero, range 0..`FRAG_LEN`, counter width `$clog2(FRAG_LEN+1)`.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_frag`=0, `out_idx`=0, `out_last`=0, `drop_count`=0, buffer and mask cleared.
- Asserting `rst_n` mid-EMIT aborts the batch immediately. Remaining fragments are lost.
- Latency: `out_valid` rises in the cycle after the capture edge.
- Throughput with `out_ready` held at 1: K kept fragments occupy K EMIT cycles, and `in_ready` returns in the cycle after the last transfer. A full batch therefore takes `INDICES_COUNT`+1 cycles, including the capture cycle.
- All fragments dropped: the block stays in IDLE, `in_ready` remains 1 in the next cycle, and `out_valid` never rises.
- `drop_count` updates on the capture edge by the number of cleared mask bits and saturates at 16'hFFFF.

## Configuration
- Macro: `FRAG_N_FILTER_EN`.
- Defined: keep bit i = (N count of slot i ≤ `MAX_N`). `drop_count` is active.
- Undefined: keep mask is all ones, every slot is emitted, and `drop_count` is tied to 0. No N-count logic is synthesized.

## Test plan
Bench configuration: `INDICES_COUNT`=4, `FRAG_LEN`=8, `BASE_LEN`=4, `MAX_N`=2.
- **Reset mid-EMIT.** Capture a batch, then pull `rst_n` low after idx1 transfers → all outputs take their reset values asynchronously, and `in_ready`=1 after release.
- **Full batch.** Fragments contain no N, `out_ready`=1 → `out_idx` 0,1,2,3 on four consecutive cycles, `out_last` only with idx3, and `in_ready`=1 in the following cycle.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles while idx1 is presented → `out_frag`/`out_idx` stay stable, and idx1 transfers exactly once when ready returns.
- **Filter partial.** With the macro defined, slot1 has 3 N and slot3 is all N → the block emits idx0 then idx2 back-to-back, `out_last` with idx2, and `drop_count`=2. With the macro undefined, the same stimulus emits all 4 slots and `drop_count`=0.
- **Filter all.** With the macro defined, all slots are all N → `out_valid` stays 0, `in_ready` stays 1, and `drop_count` increases by 4.
- **Busy ignore.** Pulse `in_valid` with new data during EMIT → the pulse is ignored, and the current batch completes unchanged.

Source files
------------

// File: rtl/frag_streamer.sv
// Batch-to-stream stage: captures INDICES_COUNT fragments and emits them one per valid/ready transfer.
// Optional 'N'-base filter enabled by defining FRAG_N_FILTER_EN.
package proj_pkg;
    localparam int unsigned EXTENDER_FRAG_LEN             = 8;
    localparam int unsigned BASE_LEN                      = 4;
    localparam int unsigned HASHER_EXTENDER_INDICES_COUNT = 4;
endpackage

module frag_streamer #(
    parameter int unsigned FRAG_LEN      = proj_pkg::EXTENDER_FRAG_LEN,
    parameter int unsigned BASE_LEN      = proj_pkg::BASE_LEN,
    parameter int unsigned INDICES_COUNT = proj_pkg::HASHER_EXTENDER_INDICES_COUNT,
    parameter int unsigned MAX_N         = 2,
    parameter int unsigned IDX_W         = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [INDICES_COUNT-1:0][FRAG_LEN*BASE_LEN-1:0] in_frags,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [FRAG_LEN*BASE_LEN-1:0]                   out_frag,
    output logic [IDX_W-1:0]                               out_idx,
    output logic                                           out_last,
    output logic [15:0]                                    drop_count
);
    localparam int unsigned FW = FRAG_LEN * BASE_LEN;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                   state;
    logic [FW-1:0]            frag_buf [INDICES_COUNT];
    logic [INDICES_COUNT-1:0] mask;
    logic [INDICES_COUNT-1:0] keep;
    logic [IDX_W:0]           cap_first, cap_after, emit_next, emit_after;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [IDX_W:0] find_set(input logic [INDICES_COUNT-1:0] m,
                                                 input int unsigned from);
        logic [IDX_W:0] r;
        r = '0;
        for (int unsigned i = 0; i < INDICES_COUNT; i++) begin
            if (i >= from && m[i] && !r[IDX_W])
                r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    // out_idx doubles as the emit pointer; the successor after next is precomputed for out_last.
    always_comb begin
        cap_first  = find_set(keep, 32'd0);
        cap_after  = find_set(keep, 32'(cap_first[IDX_W-1:0]) + 32'd1);
        emit_next  = find_set(mask, 32'(out_idx) + 32'd1);
        emit_after = find_set(mask, 32'(emit_next[IDX_W-1:0]) + 32'd1);
    end

`ifdef FRAG_N_FILTER_EN
    localparam int unsigned NCW = $clog2(FRAG_LEN + 1);
    localparam int unsigned DW  = $clog2(INDICES_COUNT + 1);

    logic [NCW-1:0] ncnt [INDICES_COUNT];
    logic [DW-1:0]  drops;
    logic [16:0]    drop_sum;

    always_comb begin
        drops = '0;
        for (int unsigned i = 0; i < INDICES_COUNT; i++) begin
            ncnt[i] = '0;
            for (int unsigned j = 0; j < FRAG_LEN; j++) begin
                if (in_frags[i][j*BASE_LEN +: BASE_LEN] == '0)
                    ncnt[i] = ncnt[i] + 1'b1;
            end
            keep[i] = (32'(ncnt[i]) <= MAX_N);
            if (!keep[i])
                drops = drops + 1'b1;
        end
    end

    assign drop_sum = {1'b0, drop_count} + 17'(drops);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= '0;
        else if (state == IDLE && in_valid)
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`else
    localparam int unsigned unused_max_n = MAX_N;

    assign keep       = '1;
    assign drop_count = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_frag  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            mask      <= '0;
            for (int unsigned i = 0; i < INDICES_COUNT; i++)
                frag_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < INDICES_COUNT; i++)
                            frag_buf[i] <= in_frags[i];
                        mask <= keep;
                        // First kept slot is loaded straight from the input so it is valid next cycle.
                        if (cap_first[IDX_W]) begin
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_frag  <= in_frags[cap_first[IDX_W-1:0]];
                            out_idx   <= cap_first[IDX_W-1:0];
                            out_last  <= !cap_after[IDX_W];
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            out_frag <= frag_buf[emit_next[IDX_W-1:0]];
                            out_idx  <= emit_next[IDX_W-1:0];
                            out_last <= !emit_after[IDX_W];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
